// File: rtl/rr_burst_arb.sv
// Round-robin burst arbiter: grants one of N requesters exclusive access to a
// shared resource for a latched, programmable number of ack'd beats.
module rr_burst_arb #(
    parameter int N      = 4,
    parameter int BEAT_W = 4,
    localparam int IDW   = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*BEAT_W-1:0]   len_m1,
    input  logic                  ack,
    output logic [N-1:0]          gnt,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy,
    output logic [BEAT_W-1:0]     beat_cnt,
    output logic                  last
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [BEAT_W-1:0] len_q;

    logic              win_found;
    logic [IDW-1:0]    win_id;
    logic [BEAT_W-1:0] win_len;
    int                scan_idx;

    // Scan upward from ptr with wrap; the first requesting index wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_len   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(scan_idx);
                win_len   = len_m1[scan_idx*BEAT_W +: BEAT_W];
            end
        end
    end

    // A beat is transferred on any rising edge in BURST where ack is high;
    // ack is a pure accept strobe from the resource and is ignored in IDLE.
    assign last = (state == BURST) && (beat_cnt == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            ptr      <= '0;
            len_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state       <= BURST;
                        gnt         <= '0;
                        gnt[win_id] <= 1'b1;
                        gnt_id      <= win_id;
                        len_q       <= win_len;
                        busy        <= 1'b1;
                        beat_cnt    <= '0;
                    end
                end
                BURST: begin
                    if (ack) begin
                        if (last) begin
                            state    <= IDLE;
                            gnt      <= '0;
                            busy     <= 1'b0;
                            beat_cnt <= '0;
                            ptr      <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_burst_arb.sv
// Self-checking bench for rr_burst_arb: per-scenario tasks plus a grant-cycle
// scoreboard fed with hand-derived {gnt_id, beat_cnt, last} expectations.
module tb_rr_burst_arb;

    localparam int N      = 4;
    localparam int BEAT_W = 4;
    localparam int IDW    = 2;
    localparam int W      = IDW + BEAT_W + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N-1:0]        req = '0;
    logic [N*BEAT_W-1:0] len_m1 = '0;
    logic                ack = 1'b0;
    logic [N-1:0]        gnt;
    logic [IDW-1:0]      gnt_id;
    logic                busy;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                last;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_e;
    logic [N-1:0] sb_oh;

    rr_burst_arb #(.N(N), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .rst(rst), .req(req), .len_m1(len_m1), .ack(ack),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .beat_cnt(beat_cnt), .last(last)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        len_m1[i*BEAT_W +: BEAT_W] = BEAT_W'(v);
    endtask

    task automatic push_exp(input int id, input int beat, input bit lst);
        exp_q.push_back({IDW'(id), BEAT_W'(beat), lst});
    endtask

    task automatic do_reset();
        req = '0;
        ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (busy) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_grant: got gnt_id=%0d beat_cnt=%0d, required no grant",
                             gnt_id, beat_cnt);
                end else begin
                    sb_e  = exp_q.pop_front();
                    sb_oh = '0;
                    sb_oh[sb_e[W-1 -: IDW]] = 1'b1;
                    if ({gnt_id, beat_cnt, last} !== sb_e || gnt !== sb_oh) begin
                        n_fail++;
                        $display("FAIL sb_beat: got gnt=%b id=%0d beat=%0d last=%b, required gnt=%b id=%0d beat=%0d last=%b",
                                 gnt, gnt_id, beat_cnt, last, sb_oh, sb_e[W-1 -: IDW], sb_e[BEAT_W:1], sb_e[0]);
                    end
                end
            end else if (gnt !== '0 || last !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_idle: got gnt=%b last=%b, required gnt=0 last=0", gnt, last);
            end
        end
    end

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: got %0d pending beats, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({gnt, gnt_id, busy, beat_cnt, last} !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got gnt=%b id=%0d busy=%b beat=%0d last=%b, required all 0",
                     gnt, gnt_id, busy, beat_cnt, last);
        end
        tick();
        tick();
        req = 4'b0001;
        set_len(0, 3);
        ack = 1'b1;
        rst = 1'b0;
        push_exp(0, 0, 0);
        push_exp(0, 1, 0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (gnt !== '0 || busy !== 1'b0 || beat_cnt !== '0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got gnt=%b busy=%b beat=%0d last=%b, required 0 0 0 0",
                     gnt, busy, beat_cnt, last);
        end
        set_len(0, 0);
        tick();
        rst = 1'b0;
        push_exp(0, 0, 1);
        tick();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_release_grant: got gnt=%b, required 0001", gnt);
        end
        req = '0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_single_beat_done: got busy=%b, required 0", busy);
        end
        check_drained("reset");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 0);
        ack = 1'b1;
        req = 4'b1111;
        for (int g = 0; g < 8; g++) push_exp(g % N, 0, 1);
        for (int g = 0; g < 8; g++) begin
            tick();
            n_checks++;
            if (gnt_id !== IDW'(g % N) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got id=%0d busy=%b, required id=%0d busy=1", g, gnt_id, busy, g % N);
            end
            if (g == 7) req = '0;
            tick();
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle_gap[%0d]: got busy=%b, required 0", g, busy);
            end
        end
        check_drained("rr");
    endtask

    task automatic test_skip_wrap();
        // pointer is 0 here; granting requester 2 moves it to 3
        ack = 1'b1;
        req = 4'b0100;
        push_exp(2, 0, 1);
        push_exp(0, 0, 1);
        push_exp(2, 0, 1);
        tick();
        req = 4'b0101;
        tick();
        tick();
        n_checks++;
        if (gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL skip_wrap_to_0: got id=%0d, required 0", gnt_id);
        end
        tick();
        tick();
        n_checks++;
        if (gnt_id !== 2'd2) begin
            n_fail++;
            $display("FAIL skip_to_2: got id=%0d, required 2", gnt_id);
        end
        req = '0;
        tick();
        check_drained("skip_wrap");
    endtask

    task automatic test_burst_stall();
        bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int beats[6] = '{0, 1, 1, 2, 3, 3};
        set_len(1, 3);
        req = 4'b0010;
        ack = 1'b1;
        for (int c = 0; c < 6; c++) push_exp(1, beats[c], beats[c] == 3);
        tick();
        req = '0;
        for (int c = 0; c < 6; c++) begin
            ack = pat[c];
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            n_fail++;
            $display("FAIL stall_end: got busy=%b gnt=%b, required 0 0000", busy, gnt);
        end
        check_drained("stall");
    endtask

    task automatic test_max_len();
        set_len(3, 15);
        req = 4'b1000;
        ack = 1'b1;
        for (int b = 0; b < 16; b++) push_exp(3, b, b == 15);
        tick();
        req = '0;
        repeat (16) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL max_len_end: got busy=%b, required 0", busy);
        end
        check_drained("max_len");
    endtask

    task automatic test_mid_burst();
        set_len(2, 2);
        req = 4'b0100;
        ack = 1'b1;
        push_exp(2, 0, 0);
        push_exp(2, 1, 0);
        push_exp(2, 2, 1);
        tick();
        req = '0;
        set_len(2, 7);
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_latched_len: got busy=%b, required 0", busy);
        end
        set_len(0, 0);
        set_len(3, 0);
        req = 4'b1001;
        push_exp(3, 0, 1);
        tick();
        n_checks++;
        if (gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_ptr_after: got id=%0d, required 3", gnt_id);
        end
        req = '0;
        tick();
        check_drained("mid");
    endtask

    task automatic test_back_to_back();
        int len;
        len = $urandom_range(0, 3);
        set_len(0, len);
        req = 4'b0001;
        ack = 1'b1;
        for (int b = 0; b < 3; b++)
            for (int k = 0; k <= len; k++) push_exp(0, k, k == len);
        for (int b = 0; b < 3; b++) begin
            tick();
            repeat (len) tick();
            if (b == 2) req = '0;
            tick();
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d]: got busy=%b, required 0 (len_m1=%0d)", b, busy, len);
            end
        end
        check_drained("b2b");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_burst_stall();
        test_max_len();
        test_mid_burst();
        test_back_to_back();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
